spi_master_mc: RTL and testbench

Parametrised Wishbone SPI master for the Zet SoC. It is the successor to the fixed 8-bit, mode-3, divide-by-4 SPI master. Additions over that block:
- programmable SCLK divider and all four CPOL/CPHA modes
- MSB- or LSB-first shifting
- parametrised slave-select count and a status register with sticky done flag
- completion interrupt and back-pressure (stall) on writes issued during a transfer

---
 rtl/spi_master_mc_if.sv | 24 ++
 rtl/spi_master_mc.sv | 185 ++++++++++++++++++
 tb/tb_spi_master_mc.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_mc_if.sv
// Wishbone slave bus bundle for spi_master_mc.
// Master drives request fields; slave returns data and ack.
interface spi_master_mc_if;
  logic [1:0]  wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/spi_master_mc.sv
// Wishbone SPI master: programmable divider, CPOL/CPHA,
// bit order, slave selects, sticky done and write stall.
module spi_master_mc #(
  parameter int          SS_WIDTH  = 8,
  parameter int          DIV_WIDTH = 8,
  parameter int unsigned DIV_RESET = 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  spi_master_mc_if.slave      wb,
  output logic                irq_o,
  output logic                sclk_o,
  output logic                mosi_o,
  input  logic                miso_i,
  output logic [SS_WIDTH-1:0] ss_o
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t               state_q;
  logic                 ack_q;
  logic [15:0]          dat_q;
  logic [DIV_WIDTH-1:0] div_q, div_l;
  logic                 cpol_q, cpha_q, lsb_q, irqen_q;
  logic                 cpol_l, cpha_l, lsb_l;
  logic                 busy_q, done_q;
  logic [7:0]           tx_q, rx_q, sh_q;
  logic [DIV_WIDTH-1:0] cnt_q;
  logic [4:0]           ecnt_q;
  logic                 sclk_q, mosi_q;
  logic [SS_WIDTH-1:0]  ss_q;

  logic                 req, dwr, stall, acc;
  logic                 start, drd, w1c;
  logic                 tick, smp;
  logic [4:0]           ecnt_n;
  logic [7:0]           sh_in;
  logic [15:0]          rdata, ctrl_rd;
  logic [15:0]          wmask, nss16;
  logic [SS_WIDTH-1:0]  ss_d;
  logic                 unused;

  assign req   = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
  assign dwr   = req & wb.wb_we_i & (wb.wb_adr_i == 2'd0);
  // DATA writes wait out an active transfer; DONE may take them.
  assign stall = dwr & ((state_q == LOAD) | (state_q == SHIFT));
  assign acc   = req & ~stall;
  assign start = acc & dwr & wb.wb_sel_i[0];
  assign drd   = acc & ~wb.wb_we_i & (wb.wb_adr_i == 2'd0);
  assign w1c   = acc & wb.wb_we_i & (wb.wb_adr_i == 2'd2)
               & wb.wb_sel_i[0] & wb.wb_dat_i[1];

  assign tick   = (cnt_q == '0);
  assign ecnt_n = ecnt_q + 5'd1;
  assign smp    = cpha_l ? ~ecnt_n[0] : ecnt_n[0];
  assign sh_in  = lsb_l ? {miso_i, sh_q[7:1]}
                        : {sh_q[6:0], miso_i};

  assign ctrl_rd = {4'h0, irqen_q, lsb_q, cpha_q, cpol_q,
                    8'(div_q)};
  assign wmask   = {{8{wb.wb_sel_i[1]}}, {8{wb.wb_sel_i[0]}}};
  assign nss16   = (16'(ss_q) & ~wmask)
                 | (wb.wb_dat_i & wmask);
  assign ss_d    = nss16[SS_WIDTH-1:0];
  assign unused  = ^{nss16, wb.wb_dat_i};

  always_comb begin
    rdata = '0;
    case (wb.wb_adr_i)
      2'd0: rdata = {8'h00, rx_q};
      2'd1: rdata = ctrl_rd;
      2'd2: rdata = {14'd0, done_q, busy_q};
      2'd3: rdata = 16'(ss_q);
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      div_q   <= DIV_WIDTH'(DIV_RESET);
      div_l   <= DIV_WIDTH'(DIV_RESET);
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      lsb_q   <= 1'b0;
      irqen_q <= 1'b0;
      cpol_l  <= 1'b0;
      cpha_l  <= 1'b0;
      lsb_l   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= 8'hff;
      rx_q    <= 8'hff;
      sh_q    <= 8'hff;
      cnt_q   <= '0;
      ecnt_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b1;
      ss_q    <= '1;
    end else begin
      ack_q <= acc;
      if (acc) dat_q <= rdata;

      if (acc & wb.wb_we_i) begin
        if (wb.wb_adr_i == 2'd1) begin
          if (wb.wb_sel_i[0])
            div_q <= wb.wb_dat_i[DIV_WIDTH-1:0];
          if (wb.wb_sel_i[1]) begin
            cpol_q  <= wb.wb_dat_i[8];
            cpha_q  <= wb.wb_dat_i[9];
            lsb_q   <= wb.wb_dat_i[10];
            irqen_q <= wb.wb_dat_i[11];
          end
        end
        if (wb.wb_adr_i == 2'd3) ss_q <= ss_d;
      end

      if (start) begin
        tx_q   <= wb.wb_dat_i[7:0];
        div_l  <= div_q;
        cpol_l <= cpol_q;
        cpha_l <= cpha_q;
        lsb_l  <= lsb_q;
        busy_q <= 1'b1;
      end

      // completion beats a same-cycle clear
      if (state_q == DONE) done_q <= 1'b1;
      else if (drd | w1c)  done_q <= 1'b0;

      case (state_q)
        IDLE: begin
          sclk_q <= cpol_q;
          mosi_q <= 1'b1;
          if (start) state_q <= LOAD;
        end
        LOAD: begin
          sh_q   <= tx_q;
          ecnt_q <= '0;
          cnt_q  <= div_l;
          sclk_q <= cpol_l;
          if (!cpha_l) mosi_q <= lsb_l ? tx_q[0] : tx_q[7];
          state_q <= SHIFT;
        end
        SHIFT: begin
          if (tick) begin
            cnt_q  <= div_l;
            sclk_q <= ~sclk_q;
            ecnt_q <= ecnt_n;
            if (smp) sh_q <= sh_in;
            else     mosi_q <= lsb_l ? sh_q[0] : sh_q[7];
            if (ecnt_n == 5'd16) begin
              rx_q    <= smp ? sh_in : sh_q;
              sclk_q  <= cpol_l;
              mosi_q  <= 1'b1;
              state_q <= DONE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DONE: begin
          busy_q  <= start;
          state_q <= start ? LOAD : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign irq_o       = done_q & irqen_q;
  assign sclk_o      = sclk_q;
  assign mosi_o      = mosi_q;
  assign ss_o        = ss_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: modes, stall,
// done/irq, mid-transfer CTRL change and async reset.
module tb_spi_master_mc;

  logic       clk;
  logic       rst_n;
  logic       irq, sclk, mosi, miso;
  logic [7:0] ss;
  logic       loop;
  logic       miso_v;

  int checks = 0;
  int errors = 0;

  spi_master_mc_if bus ();

  spi_master_mc dut (
    .wb_clk_i  (clk),
    .wb_rst_n_i(rst_n),
    .wb        (bus),
    .irq_o     (irq),
    .sclk_o    (sclk),
    .mosi_o    (mosi),
    .miso_i    (miso),
    .ss_o      (ss)
  );

  assign miso = loop ? mosi : miso_v;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wb_xact(input logic [1:0] a,
                         input logic w,
                         input logic [15:0] d,
                         input logic [1:0] s,
                         output logic [15:0] r,
                         output int waits);
    bus.wb_adr_i = a;
    bus.wb_we_i  = w;
    bus.wb_dat_i = d;
    bus.wb_sel_i = s;
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    waits = 0;
    do begin
      @(posedge clk);
      #1;
      waits++;
    end while (!bus.wb_ack_o && waits < 500);
    chk("ack", {31'd0, bus.wb_ack_o}, 32'd1);
    r = bus.wb_dat_o;
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
  endtask

  task automatic wait_irq(output int lat,
                          output logic [7:0] rb,
                          output logic [7:0] fb,
                          output int nr, output int nf,
                          output int hmin, output int hmax);
    logic ps;
    int   last;
    lat = 0; rb = 0; fb = 0; nr = 0; nf = 0;
    hmin = 1000; hmax = 0; last = -1;
    ps = sclk;
    while (!irq && lat < 2000) begin
      @(posedge clk);
      #1;
      lat++;
      if (sclk !== ps) begin
        if (last >= 0) begin
          if (lat - last < hmin) hmin = lat - last;
          if (lat - last > hmax) hmax = lat - last;
        end
        last = lat;
        if (sclk) begin
          rb = {rb[6:0], mosi};
          nr++;
        end else begin
          fb = {fb[6:0], mosi};
          nf++;
        end
        ps = sclk;
      end
    end
    chk("irq_wait", {31'd0, irq}, 32'd1);
  endtask

  logic [15:0] r;
  int          w, lat, nr, nf, hmin, hmax;
  logic [7:0]  rb, fb;

  initial begin
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = '0;
    bus.wb_we_i  = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    loop   = 1'b0;
    miso_v = 1'b1;
    rst_n  = 1'b1;
    #3 rst_n = 1'b0;
    #20;
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd1);
    chk("rst_ss", {24'd0, ss}, 32'hff);
    chk("rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_dat", {16'd0, bus.wb_dat_o}, 32'd0);
    #4 rst_n = 1'b1;
    @(posedge clk); #1;
    wb_xact(2'd2, 1'b0, 16'h0, 2'b11, r, w);
    chk("rst_status", {16'd0, r}, 32'h0);
    chk("ack_lat", w, 1);
    wb_xact(2'd1, 1'b0, 16'h0, 2'b11, r, w);
    chk("rst_ctrl", {16'd0, r}, 32'h0001);
    chk("ack_gap", w, 2);
    wb_xact(2'd0, 1'b0, 16'h0, 2'b11, r, w);
    chk("rst_rx", {16'd0, r}, 32'h00ff);

    // mode 0, MSB first, div 1, loopback
    wb_xact(2'd1, 1'b1, 16'h0801, 2'b11, r, w);
    wb_xact(2'd3, 1'b1, 16'h00fe, 2'b01, r, w);
    chk("ss_fe", {24'd0, ss}, 32'hfe);
    @(posedge clk); #1;
    chk("ack_1cyc", {31'd0, bus.wb_ack_o}, 32'd0);
    loop = 1'b1;
    wb_xact(2'd0, 1'b1, 16'h00a5, 2'b01, r, w);
    wait_irq(lat, rb, fb, nr, nf, hmin, hmax);
    chk("m0_lat", lat, 34);
    chk("m0_rises", nr, 8);
    chk("m0_mosi", {24'd0, rb}, 32'ha5);
    chk("m0_hmin", hmin, 2);
    chk("m0_hmax", hmax, 2);
    wb_xact(2'd2, 1'b0, 16'h0, 2'b11, r, w);
    chk("m0_status", {16'd0, r}, 32'h0002);
    wb_xact(2'd0, 1'b0, 16'h0, 2'b11, r, w);
    chk("m0_rx", {16'd0, r}, 32'h00a5);
    chk("m0_irq_clr", {31'd0, irq}, 32'd0);

    // mode 3, LSB first, div 0, miso high
    loop = 1'b0;
    miso_v = 1'b1;
    wb_xact(2'd1, 1'b1, 16'h0f00, 2'b11, r, w);
    @(posedge clk); #1;
    chk("m3_idle", {31'd0, sclk}, 32'd1);
    wb_xact(2'd0, 1'b1, 16'h0001, 2'b01, r, w);
    wait_irq(lat, rb, fb, nr, nf, hmin, hmax);
    chk("m3_lat", lat, 18);
    chk("m3_falls", nf, 8);
    chk("m3_mosi", {24'd0, fb}, 32'h80);
    chk("m3_half", hmax, 1);
    wb_xact(2'd2, 1'b0, 16'h0, 2'b11, r, w);
    chk("m3_status", {16'd0, r}, 32'h0002);
    wb_xact(2'd0, 1'b0, 16'h0, 2'b11, r, w);
    chk("m3_rx", {16'd0, r}, 32'h00ff);
    chk("m3_sclk_end", {31'd0, sclk}, 32'd1);

    // stalled back-to-back DATA writes
    wb_xact(2'd1, 1'b1, 16'h0801, 2'b11, r, w);
    loop = 1'b1;
    wb_xact(2'd0, 1'b1, 16'h003c, 2'b01, r, w);
    wb_xact(2'd0, 1'b1, 16'h00c3, 2'b01, r, w);
    chk("stall_wait", w, 34);
    wb_xact(2'd0, 1'b0, 16'h0, 2'b11, r, w);
    chk("stall_rx1", {16'd0, r}, 32'h003c);
    wait_irq(lat, rb, fb, nr, nf, hmin, hmax);
    chk("stall_lat2", lat, 32);
    chk("stall_mosi2", {24'd0, rb}, 32'hc3);
    wb_xact(2'd0, 1'b0, 16'h0, 2'b11, r, w);
    chk("stall_rx2", {16'd0, r}, 32'h00c3);

    // done set collides with W1C clear
    wb_xact(2'd1, 1'b1, 16'h0800, 2'b11, r, w);
    wb_xact(2'd0, 1'b1, 16'h005a, 2'b01, r, w);
    repeat (17) @(posedge clk);
    #1;
    wb_xact(2'd2, 1'b1, 16'h0002, 2'b01, r, w);
    chk("coll_wait", w, 1);
    wb_xact(2'd2, 1'b0, 16'h0, 2'b11, r, w);
    chk("coll_done", {16'd0, r}, 32'h0002);
    chk("coll_irq", {31'd0, irq}, 32'd1);
    wb_xact(2'd2, 1'b1, 16'h0002, 2'b01, r, w);
    wb_xact(2'd2, 1'b0, 16'h0, 2'b11, r, w);
    chk("w1c_done", {16'd0, r}, 32'h0000);
    chk("w1c_irq", {31'd0, irq}, 32'd0);

    // CTRL change mid-transfer applies to next transfer
    wb_xact(2'd1, 1'b1, 16'h0801, 2'b11, r, w);
    wb_xact(2'd0, 1'b1, 16'h0096, 2'b01, r, w);
    wb_xact(2'd1, 1'b1, 16'h0807, 2'b11, r, w);
    wait_irq(lat, rb, fb, nr, nf, hmin, hmax);
    chk("cb_lat1", lat, 32);
    chk("cb_hmin1", hmin, 2);
    chk("cb_hmax1", hmax, 2);
    wb_xact(2'd1, 1'b0, 16'h0, 2'b11, r, w);
    chk("cb_ctrl", {16'd0, r}, 32'h0807);
    wb_xact(2'd0, 1'b0, 16'h0, 2'b11, r, w);
    chk("cb_rx1", {16'd0, r}, 32'h0096);
    wb_xact(2'd0, 1'b1, 16'h0069, 2'b01, r, w);
    wait_irq(lat, rb, fb, nr, nf, hmin, hmax);
    chk("cb_lat2", lat, 130);
    chk("cb_hmin2", hmin, 8);
    chk("cb_hmax2", hmax, 8);
    chk("cb_mosi2", {24'd0, rb}, 32'h69);
    wb_xact(2'd0, 1'b0, 16'h0, 2'b11, r, w);
    chk("cb_rx2", {16'd0, r}, 32'h0069);

    // asynchronous reset in the middle of a transfer
    loop = 1'b0;
    miso_v = 1'b0;
    wb_xact(2'd1, 1'b1, 16'h0003, 2'b11, r, w);
    wb_xact(2'd0, 1'b1, 16'h0000, 2'b01, r, w);
    repeat (6) @(posedge clk);
    #1;
    chk("pre_sclk", {31'd0, sclk}, 32'd1);
    chk("pre_mosi", {31'd0, mosi}, 32'd0);
    chk("pre_ss", {24'd0, ss}, 32'hfe);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_sclk", {31'd0, sclk}, 32'd0);
    chk("ar_mosi", {31'd0, mosi}, 32'd1);
    chk("ar_ss", {24'd0, ss}, 32'hff);
    chk("ar_ack", {31'd0, bus.wb_ack_o}, 32'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    wb_xact(2'd2, 1'b0, 16'h0, 2'b11, r, w);
    chk("ar_status", {16'd0, r}, 32'h0000);
    wb_xact(2'd1, 1'b0, 16'h0, 2'b11, r, w);
    chk("ar_ctrl", {16'd0, r}, 32'h0001);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
